// File: rtl/prod_stream_if.sv
// Beat stream between a producer and its consumer: payload, valid and last
// move downstream, ready moves back upstream.
interface prod_stream_if #(
   parameter int DATA_W = 8
);
   logic              val;
   logic [DATA_W-1:0] data;
   logic              last;
   logic              rdy;

   modport master (output val, data, last, input rdy);
   modport slave  (input val, data, last, output rdy);
endinterface

// File: rtl/prod_stream.sv
// Burst stimulus producer: BURST_LEN beats, then GAP idle cycles. Each beat
// comes from a counter, a range-limited LFSR or a constant, chosen per burst.
module prod_stream #(
   parameter int          DATA_W    = 8,
   parameter int          BURST_LEN = 4,
   parameter int          GAP       = 2,
   parameter int          MAX_VAL   = 5,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          en_i,
   input  logic [1:0]    mode_i,
   prod_stream_if.master bus,
   output logic [15:0]   beat_cnt_o,
   output logic          busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_e;
   typedef enum logic [1:0] {M_CNT = 2'd0, M_RND = 2'd1, M_CONST = 2'd2} mode_e;

   localparam int                IW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int                GW        = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [IW-1:0]     IDX_LAST  = IW'(BURST_LEN - 1);
   localparam logic [GW-1:0]     GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [16:0]       RND_MOD   = 17'(MAX_VAL + 1);
   localparam logic [31:0]       MAX_VAL_W = 32'(MAX_VAL);
   localparam logic [DATA_W-1:0] CONST_VAL = MAX_VAL_W[DATA_W-1:0];

   state_e            state_q;
   mode_e             mode_q;
   mode_e             mode_d;
   logic [IW-1:0]     beat_idx_q;
   logic [GW-1:0]     gap_cnt_q;
   logic [DATA_W-1:0] cnt_q, cnt_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [15:0]       beat_cnt_q, beat_cnt_d;
   logic              val_q, last_q;
   logic              accept;
   logic [DATA_W-1:0] rnd_val;
   logic [DATA_W-1:0] data_raw;

   assign accept = val_q & bus.rdy;

   // Reserved mode encoding runs as the counter.
   assign mode_d = (mode_i == 2'd3) ? M_CNT : mode_e'(mode_i);

   assign cnt_d      = cnt_q + DATA_W'(1);
   assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign beat_cnt_d = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;
   assign rnd_val    = DATA_W'({1'b0, lfsr_q} % RND_MOD);

   always_comb begin
      data_raw = cnt_q;
      case (mode_q)
         M_RND:   data_raw = rnd_val;
         M_CONST: data_raw = CONST_VAL;
         default: data_raw = cnt_q;
      endcase
   end

   // Payload is a pure function of registered state, so it cannot move
   // during a stall and rdy never reaches val or data combinationally.
   assign bus.val    = val_q;
   assign bus.last   = last_q;
   assign bus.data   = val_q ? data_raw : '0;
   assign beat_cnt_o = beat_cnt_q;
   assign busy_o     = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q      <= '0;
         lfsr_q     <= LFSR_SEED;
         beat_cnt_q <= '0;
      end else if (accept) begin
         beat_cnt_q <= beat_cnt_d;
         case (mode_q)
            M_RND:   lfsr_q <= lfsr_d;
            M_CONST: ;
            default: cnt_q <= cnt_d;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= S_IDLE;
         mode_q     <= M_CNT;
         beat_idx_q <= '0;
         gap_cnt_q  <= '0;
         val_q      <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (en_i) begin
                  state_q    <= S_SEND;
                  mode_q     <= mode_d;
                  beat_idx_q <= '0;
                  val_q      <= 1'b1;
                  last_q     <= (IDX_LAST == '0);
               end
            end
            S_SEND: begin
               if (accept) begin
                  if (beat_idx_q != IDX_LAST) begin
                     beat_idx_q <= beat_idx_q + IW'(1);
                     last_q     <= ((beat_idx_q + IW'(1)) == IDX_LAST);
                  end else if (GAP > 0) begin
                     state_q   <= S_GAP;
                     gap_cnt_q <= '0;
                     val_q     <= 1'b0;
                     last_q    <= 1'b0;
                  end else if (en_i) begin
                     mode_q     <= mode_d;
                     beat_idx_q <= '0;
                     last_q     <= (IDX_LAST == '0);
                  end else begin
                     state_q <= S_IDLE;
                     val_q   <= 1'b0;
                     last_q  <= 1'b0;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  if (en_i) begin
                     state_q    <= S_SEND;
                     mode_q     <= mode_d;
                     beat_idx_q <= '0;
                     val_q      <= 1'b1;
                     last_q     <= (IDX_LAST == '0);
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + GW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               val_q   <= 1'b0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

   // A stalled beat stays offered and unchanged until it is taken.
   a_stall_hold: assert property (@(posedge clk) disable iff (!rst_b)
      (bus.val && !bus.rdy) |=> (bus.val && $stable(bus.data) && $stable(bus.last)));
   a_last_valid: assert property (@(posedge clk) disable iff (!rst_b)
      bus.last |-> bus.val);

endmodule

// File: tb/tb_prod_stream.sv
// Bench for prod_stream: default-parameter instance plus a BURST_LEN=1,
// GAP=0, 3-bit instance, checked against a beat-level model.
module tb_prod_stream;
   localparam int DW  = 8;
   localparam int BL  = 4;
   localparam int GP  = 2;
   localparam int MV  = 5;
   localparam int DW2 = 3;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        en = 1'b0, en2 = 1'b0;
   logic [1:0]  mode = 2'd0, mode2 = 2'd0;
   logic [15:0] beat_cnt, beat_cnt2;
   logic        busy, busy2;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          m_cnt;
   logic [15:0] m_lfsr;
   int          m_beats;

   prod_stream_if #(.DATA_W(DW))  bus  ();
   prod_stream_if #(.DATA_W(DW2)) bus2 ();

   prod_stream #(.DATA_W(DW), .BURST_LEN(BL), .GAP(GP), .MAX_VAL(MV),
                 .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .rst_b(rst_b), .en_i(en), .mode_i(mode), .bus(bus),
      .beat_cnt_o(beat_cnt), .busy_o(busy));

   prod_stream #(.DATA_W(DW2), .BURST_LEN(1), .GAP(0), .MAX_VAL(MV),
                 .LFSR_SEED(16'hACE1)) dut2 (
      .clk(clk), .rst_b(rst_b), .en_i(en2), .mode_i(mode2), .bus(bus2),
      .beat_cnt_o(beat_cnt2), .busy_o(busy2));

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_b = 1'b0; en = 1'b0; en2 = 1'b0; mode = 2'd0; mode2 = 2'd0;
      bus.rdy = 1'b0; bus2.rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_b = 1'b1;
      m_cnt = 0; m_lfsr = 16'hACE1; m_beats = 0;
   endtask

   task automatic test_reset();
      rst_b = 1'b0; bus.rdy = 1'b1; bus2.rdy = 1'b1;
      tick();
      n_cmp++;
      if ({bus.val, bus.last, bus.data, beat_cnt, busy} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got val=%b last=%b data=%h cnt=%h busy=%b want all 0",
                  bus.val, bus.last, bus.data, beat_cnt, busy);
      end
      n_cmp++;
      if ({bus2.val, bus2.data, beat_cnt2, busy2} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs2: got val=%b data=%h cnt=%h want 0", bus2.val, bus2.data, beat_cnt2);
      end
   endtask

   task automatic test_counter_flow();
      do_reset();
      mode = 2'd0; bus.rdy = 1'b1; en = 1'b1;
      tick();
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < BL; k++) begin
            logic [DW-1:0] ed;
            ed = DW'(m_cnt);
            n_cmp++;
            if ({bus.val, bus.last, bus.data} !== {1'b1, k == BL - 1, ed}) begin
               n_bad++;
               $display("FAIL cnt_beat b%0d k%0d: got v%b l%b d%h want v1 l%b d%h",
                        b, k, bus.val, bus.last, bus.data, k == BL - 1, ed);
            end
            tick(); m_cnt++; m_beats++;
         end
         if (b == 1) en = 1'b0;
         for (int g = 0; g < GP; g++) begin
            n_cmp++;
            if ({bus.val, bus.last, bus.data, busy} !== {2'b00, {DW{1'b0}}, 1'b1}) begin
               n_bad++;
               $display("FAIL cnt_gap b%0d g%0d: got v%b l%b d%h busy%b want v0 l0 d0 busy1",
                        b, g, bus.val, bus.last, bus.data, busy);
            end
            tick();
         end
      end
      n_cmp++;
      if ({bus.val, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL cnt_idle: got val=%b busy=%b want 0 0", bus.val, busy);
      end
      n_cmp++;
      if (beat_cnt !== 16'(m_beats)) begin
         n_bad++;
         $display("FAIL cnt_beat_cnt: got %0d want %0d", beat_cnt, m_beats);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      mode = 2'd0; bus.rdy = 1'b1; en = 1'b1;
      tick();
      n_cmp++;
      if ({bus.val, bus.data} !== {1'b1, DW'(0)}) begin
         n_bad++;
         $display("FAIL bp_first: got v%b d%h want v1 d0", bus.val, bus.data);
      end
      tick(); m_cnt++; m_beats++;
      bus.rdy = 1'b0;
      for (int s = 0; s < 3; s++) begin
         tick();
         n_cmp++;
         if ({bus.val, bus.last, bus.data, beat_cnt} !== {2'b10, DW'(m_cnt), 16'(m_beats)}) begin
            n_bad++;
            $display("FAIL bp_stall s%0d: got v%b l%b d%h cnt%0d want v1 l0 d%h cnt%0d",
                     s, bus.val, bus.last, bus.data, beat_cnt, DW'(m_cnt), m_beats);
         end
      end
      bus.rdy = 1'b1;
      tick(); m_cnt++; m_beats++;
      n_cmp++;
      if ({bus.val, bus.data, beat_cnt} !== {1'b1, DW'(m_cnt), 16'(m_beats)}) begin
         n_bad++;
         $display("FAIL bp_resume: got v%b d%h cnt%0d want v1 d%h cnt%0d",
                  bus.val, bus.data, beat_cnt, DW'(m_cnt), m_beats);
      end
   endtask

   task automatic test_random();
      int acc = 0, bidx = 0, idle_run = 0, cyc = 0;
      bit after_last = 1'b0, stall_prev = 1'b0, acc_now;
      do_reset();
      mode = 2'd1; en = 1'b1; bus.rdy = 1'b0;
      tick();
      while (acc < 1000 && cyc < 20000) begin
         bus.rdy = 1'($urandom_range(0, 1));
         if (stall_prev) begin
            n_cmp++;
            if (bus.val !== 1'b1) begin
               n_bad++;
               $display("FAIL rnd_stall_val: got %b want 1 at beat %0d", bus.val, acc);
            end
         end
         if (bus.val === 1'b1) begin
            logic [DW-1:0] ed;
            ed = DW'(m_lfsr % (MV + 1));
            n_cmp++;
            if ({bus.last, bus.data} !== {bidx == BL - 1, ed} || bus.data > MV) begin
               n_bad++;
               $display("FAIL rnd_beat %0d: got l%b d%h want l%b d%h",
                        acc, bus.last, bus.data, bidx == BL - 1, ed);
            end
            if (after_last) begin
               n_cmp++;
               if (idle_run != GP) begin
                  n_bad++;
                  $display("FAIL rnd_gap: got %0d idle cycles want %0d", idle_run, GP);
               end
               after_last = 1'b0;
            end
         end else begin
            idle_run++;
         end
         acc_now    = bus.val & bus.rdy;
         stall_prev = bus.val & ~bus.rdy;
         tick(); cyc++;
         if (acc_now) begin
            m_lfsr = lfsr_next(m_lfsr); acc++; m_beats++;
            if (bidx == BL - 1) begin
               bidx = 0; after_last = 1'b1; idle_run = 0;
            end else begin
               bidx++;
            end
         end
      end
      n_cmp++;
      if (acc != 1000) begin
         n_bad++;
         $display("FAIL rnd_timeout: got %0d accepted beats want 1000", acc);
      end
      n_cmp++;
      if (beat_cnt !== 16'(m_beats)) begin
         n_bad++;
         $display("FAIL rnd_beat_cnt: got %0d want %0d", beat_cnt, m_beats);
      end
   endtask

   task automatic test_en_drop();
      do_reset();
      mode = 2'd0; bus.rdy = 1'b1; en = 1'b1;
      tick();
      for (int k = 0; k < BL; k++) begin
         if (k == 1) en = 1'b0;
         n_cmp++;
         if ({bus.val, bus.last, bus.data} !== {1'b1, k == BL - 1, DW'(m_cnt)}) begin
            n_bad++;
            $display("FAIL endrop_beat k%0d: got v%b l%b d%h want v1 l%b d%h",
                     k, bus.val, bus.last, bus.data, k == BL - 1, DW'(m_cnt));
         end
         tick(); m_cnt++; m_beats++;
      end
      for (int g = 0; g < GP; g++) begin
         n_cmp++;
         if ({bus.val, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL endrop_gap g%0d: got v%b busy%b want v0 busy1", g, bus.val, busy);
         end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({bus.val, bus.data, busy} !== {1'b0, {DW{1'b0}}, 1'b0}) begin
            n_bad++;
            $display("FAIL endrop_idle i%0d: got v%b d%h busy%b want 0 0 0", i, bus.val, bus.data, busy);
         end
         tick();
      end
   endtask

   task automatic test_mode_switch();
      int bm[3] = '{0, 2, 3};
      do_reset();
      mode = 2'd0; bus.rdy = 1'b1; en = 1'b1;
      tick();
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < BL; k++) begin
            logic [DW-1:0] ed;
            if (k == 1) mode = (b < 2) ? 2'(bm[b + 1]) : 2'd1;
            ed = (bm[b] == 2) ? DW'(MV) : DW'(m_cnt);
            n_cmp++;
            if ({bus.val, bus.data} !== {1'b1, ed}) begin
               n_bad++;
               $display("FAIL mode_beat b%0d k%0d: got v%b d%h want v1 d%h", b, k, bus.val, bus.data, ed);
            end
            tick(); m_beats++;
            if (bm[b] != 2) m_cnt++;
         end
         if (b == 2) en = 1'b0;
         repeat (GP) tick();
      end
      n_cmp++;
      if ({busy, beat_cnt} !== {1'b0, 16'(m_beats)}) begin
         n_bad++;
         $display("FAIL mode_end: got busy%b cnt%0d want busy0 cnt%0d", busy, beat_cnt, m_beats);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      mode = 2'd0; bus.rdy = 1'b1; en = 1'b1;
      tick();
      tick();
      n_cmp++;
      if ({bus.val, bus.data, beat_cnt} !== {1'b1, DW'(1), 16'd1}) begin
         n_bad++;
         $display("FAIL arst_pre: got v%b d%h cnt%0d want v1 d01 cnt1", bus.val, bus.data, beat_cnt);
      end
      #2 rst_b = 1'b0;
      #1;
      n_cmp++;
      if ({bus.val, bus.last, bus.data, beat_cnt, busy} !== '0) begin
         n_bad++;
         $display("FAIL arst_now: got v%b l%b d%h cnt%0d busy%b want all 0",
                  bus.val, bus.last, bus.data, beat_cnt, busy);
      end
      @(negedge clk);
      rst_b = 1'b1;
      tick();
      n_cmp++;
      if ({bus.val, bus.data, beat_cnt} !== {1'b1, DW'(0), 16'd0}) begin
         n_bad++;
         $display("FAIL arst_restart: got v%b d%h cnt%0d want v1 d00 cnt0", bus.val, bus.data, beat_cnt);
      end
   endtask

   task automatic test_bl1_saturate();
      int m2 = 0;
      do_reset();
      mode2 = 2'd0; bus2.rdy = 1'b1; en2 = 1'b1;
      tick();
      for (int k = 0; k < 20; k++) begin
         n_cmp++;
         if ({bus2.val, bus2.last, bus2.data} !== {2'b11, DW2'(k)}) begin
            n_bad++;
            $display("FAIL bl1_beat k%0d: got v%b l%b d%h want v1 l1 d%h",
                     k, bus2.val, bus2.last, bus2.data, DW2'(k));
         end
         tick(); m2++;
      end
      repeat (65540) tick();
      m2 += 65540;
      n_cmp++;
      if (beat_cnt2 !== ((m2 > 65535) ? 16'hFFFF : 16'(m2))) begin
         n_bad++;
         $display("FAIL bl1_sat: got %h want ffff", beat_cnt2);
      end
      tick();
      n_cmp++;
      if ({beat_cnt2, bus2.val} !== {16'hFFFF, 1'b1}) begin
         n_bad++;
         $display("FAIL bl1_sat_hold: got cnt %h v%b want ffff v1", beat_cnt2, bus2.val);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_counter_flow();
      test_backpressure();
      test_random();
      test_en_drop();
      test_mode_switch();
      test_async_reset();
      test_bl1_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
